fifo_frame_builder: RTL and testbench



---
 rtl/frame_pkg.sv | 22 ++
 rtl/frame_payload_buf.sv | 24 ++
 rtl/fifo_frame_builder.sv | 131 +++++++++++++
 tb/tb_fifo_frame_builder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared types and helpers for the FIFO frame builder.
package frame_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SOF,
    ST_LEN,
    ST_PAYLOAD,
    ST_CKSUM
  } frame_state_t;

  localparam byte_t SOF_BYTE_DEF = 8'h7E;

  // Running XOR checksum step.
  function automatic byte_t xor_update(byte_t acc, byte_t d);
    return acc ^ d;
  endfunction

endpackage

// File: rtl/frame_payload_buf.sv
// Payload register file: one write port, asynchronous read, storage not reset.
module frame_payload_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Capture the byte returned by the FIFO into its payload slot.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fifo_frame_builder.sv
// Drains the FIFO read side into a payload buffer and emits SOF/LEN/payload/XOR frames.
module fifo_frame_builder
  import frame_pkg::*;
#(
  parameter int    DATA_W         = 8,
  parameter int    MAX_PAYLOAD    = 16,
  parameter int    TIMEOUT_CYCLES = 32,
  parameter byte_t SOF_BYTE       = SOF_BYTE_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EMPTY,
  input  logic [DATA_W-1:0] READ_DATA,
  output logic              READ_ENABLE,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  output logic              TX_LAST,
  output logic              BUSY
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  frame_state_t      state, state_nxt;
  logic [CW-1:0]     count, idx;
  logic              pending;
  logic [TW-1:0]     tmo;
  byte_t             cksum;
  logic [DATA_W-1:0] buf_rd;
  logic              room, rd_en, tx_hs, len_done, tmo_done;

  frame_payload_buf #(.DATA_W(DATA_W), .DEPTH(MAX_PAYLOAD), .AW(AW)) u_buf (
    .clk     (CLK),
    .wr_en   (pending),
    .wr_idx  (count[AW-1:0]),
    .wr_data (READ_DATA),
    .rd_idx  (idx[AW-1:0]),
    .rd_data (buf_rd)
  );

  // In-flight read counts against capacity so we never over-read the FIFO.
  assign room     = ({1'b0, count} + {{CW{1'b0}}, pending}) < (CW+1)'(MAX_PAYLOAD);
  assign rd_en    = RST && (state == ST_COLLECT) && !EMPTY && room;
  assign tx_hs    = TX_VALID && TX_READY;
  assign len_done = (count == CW'(MAX_PAYLOAD)) && !pending;
  // Never close while a byte is still on its way from the FIFO.
  assign tmo_done = (tmo == TW'(TIMEOUT_CYCLES)) && !pending && !rd_en;

  assign READ_ENABLE = rd_en;
  assign BUSY        = (state != ST_IDLE);

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state and TX outputs, all decoded from registered state.
  always_comb begin
    state_nxt = state;
    TX_VALID  = 1'b0;
    TX_DATA   = '0;
    TX_LAST   = 1'b0;
    case (state)
      ST_IDLE:    if (!EMPTY) state_nxt = ST_COLLECT;
      ST_COLLECT: if (len_done || tmo_done) state_nxt = ST_SOF;
      ST_SOF: begin
        TX_VALID = 1'b1;
        TX_DATA  = SOF_BYTE;
        if (tx_hs) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        TX_VALID = 1'b1;
        TX_DATA  = DATA_W'(count);
        if (tx_hs) state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        TX_VALID = 1'b1;
        TX_DATA  = buf_rd;
        if (tx_hs && (idx == count - CW'(1))) state_nxt = ST_CKSUM;
      end
      ST_CKSUM: begin
        TX_VALID = 1'b1;
        TX_DATA  = cksum;
        TX_LAST  = 1'b1;
        if (tx_hs) state_nxt = EMPTY ? ST_IDLE : ST_COLLECT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Collection bookkeeping, idle timeout and checksum accumulation.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      count   <= '0;
      idx     <= '0;
      pending <= 1'b0;
      tmo     <= '0;
      cksum   <= '0;
    end else begin
      pending <= rd_en;
      if (pending) count <= count + CW'(1);
      if (rd_en)
        tmo <= '0;
      else if ((state == ST_COLLECT) && EMPTY && !pending && (count != '0) &&
               (tmo != TW'(TIMEOUT_CYCLES)))
        tmo <= tmo + TW'(1);
      if (tx_hs) begin
        case (state)
          ST_SOF: begin
            cksum <= byte_t'(count);
            idx   <= '0;
          end
          ST_PAYLOAD: begin
            cksum <= xor_update(cksum, buf_rd);
            idx   <= idx + CW'(1);
          end
          ST_CKSUM: begin
            count <= '0;
            idx   <= '0;
            tmo   <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_frame_builder.sv
// Directed bench for fifo_frame_builder with a behavioural FIFO read side.
module tb_fifo_frame_builder;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EMPTY;
  logic [7:0] READ_DATA = 8'h00;
  logic       READ_ENABLE;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY = 1'b1;
  logic       TX_LAST;
  logic       BUSY;

  always #5 CLK = ~CLK;

  fifo_frame_builder dut (
    .CLK(CLK), .RST(RST), .EMPTY(EMPTY), .READ_DATA(READ_DATA),
    .READ_ENABLE(READ_ENABLE), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .TX_LAST(TX_LAST), .BUSY(BUSY)
  );

  // FIFO model: pushes from the stimulus, pops on READ_ENABLE with 1-cycle data.
  logic [7:0] fmem [128];
  logic [6:0] push_cnt = '0;
  logic [6:0] pop_cnt  = '0;
  logic       flick_en = 1'b0;
  logic       flick_ph = 1'b0;
  assign EMPTY = (push_cnt == pop_cnt) || (flick_en && flick_ph);

  // Monitor state.
  logic [7:0] cap  [256];
  logic       capl [256];
  int cap_n = 0, frames = 0, cyc = 0, rd_cyc = 0, sof_cyc = 0;
  int rd_since = 0, re_empty = 0, re_tx = 0, over = 0, stab_bad = 0;
  logic first = 1'b1, stall_q = 1'b0, stall_l = 1'b0;
  logic [7:0] stall_d = 8'h00;

  int tests = 0, fails = 0;
  logic bp = 1'b0;
  logic [7:0] pl [19];

  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    flick_ph <= ~flick_ph;
    if (READ_ENABLE) begin
      READ_DATA <= fmem[pop_cnt];
      pop_cnt   <= pop_cnt + 7'd1;
      rd_cyc    <= cyc;
      if (EMPTY) re_empty <= re_empty + 1;
      if (TX_VALID) re_tx <= re_tx + 1;
      if (rd_since >= 16) over <= over + 1;
      rd_since <= rd_since + 1;
    end
    if (TX_VALID && TX_READY) begin
      cap[cap_n]  <= TX_DATA;
      capl[cap_n] <= TX_LAST;
      cap_n       <= cap_n + 1;
      if (first) begin
        sof_cyc <= cyc;
        first   <= 1'b0;
      end
      if (TX_LAST) begin
        frames   <= frames + 1;
        rd_since <= 0;
        first    <= 1'b1;
      end
    end
    if (stall_q && (TX_DATA !== stall_d || TX_LAST !== stall_l || TX_VALID !== 1'b1))
      stab_bad <= stab_bad + 1;
    stall_q <= TX_VALID && !TX_READY;
    stall_d <= TX_DATA;
    stall_l <= TX_LAST;
    if (!RST) begin
      rd_since <= 0;
      first    <= 1'b1;
      stall_q  <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i);
    fmem[push_cnt] = pl[i];
    push_cnt = push_cnt + 7'd1;
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int k = 0;
    while (frames < target && k < budget) begin
      @(negedge CLK);
      if (bp) TX_READY = ~TX_READY;
      k++;
    end
    chk({tag, ".done"}, 32'(frames >= target), 32'd1);
  endtask

  // Compare one captured frame against SOF, length, payload pl[ps..], checksum, last flags.
  task automatic chk_frame(input string tag, input int off, input int ps, input int n,
                           input logic [7:0] ck);
    chk({tag, ".sof"}, 32'(cap[off]), 32'h7E);
    chk({tag, ".len"}, 32'(cap[off+1]), 32'(n));
    for (int i = 0; i < n; i++) chk({tag, ".pay"}, 32'(cap[off+2+i]), 32'(pl[ps+i]));
    chk({tag, ".ck"}, 32'(cap[off+2+n]), 32'(ck));
    for (int i = 0; i < n + 3; i++) chk({tag, ".last"}, 32'(capl[off+i]), 32'(i == n + 2));
  endtask

  initial begin
    int base, base2, tgt, k;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA,
           8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h01, 8'h03, 8'h05, 8'h06};

    // Reset with the FIFO already loaded for the full-frame case.
    for (int i = 0; i < 16; i++) push(i);
    repeat (3) @(negedge CLK);
    chk("rst.re",    32'(READ_ENABLE), 32'd0);
    chk("rst.valid", 32'(TX_VALID), 32'd0);
    chk("rst.last",  32'(TX_LAST), 32'd0);
    chk("rst.busy",  32'(BUSY), 32'd0);
    chk("rst.data",  32'(TX_DATA), 32'd0);
    RST = 1'b1;

    // Full 16-byte frame.
    wait_frames("t1", 1, 200);
    chk_frame("t1", 0, 0, 16, 8'h11);
    chk("t1.reads", 32'(pop_cnt), 32'd16);
    chk("t1.len", 32'(cap_n), 32'd19);

    // Timeout-closed short frame.
    base = cap_n;
    for (int i = 16; i < 19; i++) push(i);
    wait_frames("t2", 2, 200);
    chk_frame("t2", base, 16, 3, 8'h03);
    chk("t2.lat", 32'(sof_cyc - rd_cyc), 32'd35);

    // 19 bytes split into a full frame and a timeout frame.
    base = cap_n;
    for (int i = 0; i < 19; i++) push(i);
    wait_frames("t3", 4, 400);
    chk_frame("t3a", base, 0, 16, 8'h11);
    chk_frame("t3b", base + 19, 16, 3, 8'h03);
    chk("t3.n", 32'(cap_n - base), 32'd25);

    // Backpressure: TX_READY alternates.
    base = cap_n;
    bp = 1'b1;
    for (int i = 0; i < 16; i++) push(i);
    wait_frames("t4", 5, 400);
    bp = 1'b0;
    TX_READY = 1'b1;
    chk_frame("t4", base, 0, 16, 8'h11);
    chk("t4.stable", 32'(stab_bad), 32'd0);
    chk("t4.re_tx", 32'(re_tx), 32'd0);

    // Reset while payload byte 5 is on the wire.
    @(negedge CLK);
    base = cap_n;
    for (int i = 0; i < 16; i++) push(i);
    k = 0;
    while (cap_n < base + 7 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    chk("t5.reach", 32'(cap_n), 32'(base + 7));
    RST = 1'b0;
    @(negedge CLK);
    chk("t5.valid", 32'(TX_VALID), 32'd0);
    chk("t5.re",    32'(READ_ENABLE), 32'd0);
    chk("t5.busy",  32'(BUSY), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    base2 = cap_n;
    tgt = frames + 1;
    for (int i = 16; i < 19; i++) push(i);
    wait_frames("t5", tgt, 200);
    chk_frame("t5", base2, 16, 3, 8'h03);
    chk("t5.n", 32'(cap_n - base2), 32'd6);

    // Flickering EMPTY.
    flick_en = 1'b1;
    base = cap_n;
    tgt = frames + 2;
    for (int i = 0; i < 19; i++) push(i);
    wait_frames("t6", tgt, 600);
    flick_en = 1'b0;
    chk_frame("t6a", base, 0, 16, 8'h11);
    chk_frame("t6b", base + 19, 16, 3, 8'h03);

    // Global read-side invariants over the whole run.
    chk("g.re_empty", 32'(re_empty), 32'd0);
    chk("g.over",     32'(over), 32'd0);
    chk("g.re_tx",    32'(re_tx), 32'd0);
    chk("g.stable",   32'(stab_bad), 32'd0);
    chk("g.drained",  32'(pop_cnt), 32'(push_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
